// File: rtl/app_layer_seq_accum.sv
// Radix-4 shift-add controller/accumulator driving an app_layer_unsigned partial-product layer.
// Optional saturating accumulate when APP_LAYER_ACC_SAT_EN is defined; wraps otherwise.
module app_layer_seq_accum #(
  parameter int unsigned WIDTH1 = 8,
  parameter int unsigned WIDTH2 = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH1-1:0]         in_a,
  input  logic [WIDTH2-1:0]         in_b,
  output logic [WIDTH1-1:0]         lyr_a,
  output logic                      lyr_b_low,
  output logic                      lyr_b_high,
  output logic                      lyr_cin,
  input  logic [WIDTH1+1:0]         lyr_sum,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH1+WIDTH2-1:0]  out_prod,
  output logic                      out_ovf
);

  localparam int unsigned LAYERS = WIDTH2 / 2;
  localparam int unsigned PW     = WIDTH1 + WIDTH2;
  localparam int unsigned KW     = (LAYERS > 1) ? $clog2(LAYERS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nx;
  logic [WIDTH1-1:0] a_reg;
  logic [WIDTH2-1:0] b_sh, b_nx;
  logic [KW-1:0]     k;
  logic [PW-1:0]     acc, acc_nx, addend;
  logic              last_c, accept_c;

  assign last_c   = (k == KW'(LAYERS - 1));
  assign accept_c = (state == IDLE) && in_valid;
  assign b_nx     = b_sh >> 2;
  // Zero-extend the layer sum, then weight it by 4^k.
  assign addend   = PW'(lyr_sum) << {k, 1'b0};

`ifdef APP_LAYER_ACC_SAT_EN
  logic          ovf, ovf_nx;
  logic [PW:0]   sum;

  // Any carry out of the product range pins the accumulator at all ones.
  always_comb begin
    sum    = {1'b0, acc} + {1'b0, addend};
    ovf_nx = ovf | sum[PW];
    acc_nx = ovf_nx ? '1 : sum[PW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (accept_c) begin
      ovf <= 1'b0;
    end else if (state == RUN) begin
      ovf <= ovf_nx;
    end
  end

  assign out_ovf = ovf;
`else
  assign acc_nx  = acc + addend;
  assign out_ovf = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last_c)    state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Operand latch, multiplier shifter, step counter and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_sh  <= '0;
      k     <= '0;
      acc   <= '0;
    end else if (accept_c) begin
      a_reg <= in_a;
      b_sh  <= in_b;
      k     <= '0;
      acc   <= '0;
    end else if (state == RUN) begin
      acc   <= acc_nx;
      b_sh  <= b_nx;
      k     <= k + KW'(1);
    end
  end

  // Handshake flags and layer bit-pair, registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      lyr_b_low  <= 1'b0;
      lyr_b_high <= 1'b0;
    end else begin
      in_ready  <= (state_nx == IDLE);
      out_valid <= (state_nx == DONE);
      if (accept_c) begin
        lyr_b_low  <= in_b[0];
        lyr_b_high <= in_b[1];
      end else if ((state == RUN) && !last_c) begin
        lyr_b_low  <= b_nx[0];
        lyr_b_high <= b_nx[1];
      end else begin
        lyr_b_low  <= 1'b0;
        lyr_b_high <= 1'b0;
      end
    end
  end

  assign lyr_a    = a_reg;
  assign lyr_cin  = 1'b0;
  assign out_prod = acc;

endmodule

// File: tb/tb_app_layer_seq_accum.sv
// Self-checking bench for app_layer_seq_accum with an exact/stub/random layer model.
module tb_app_layer_seq_accum;

  localparam int unsigned W1 = 8;
  localparam int unsigned W2 = 8;
  localparam int unsigned L  = W2 / 2;
  localparam int unsigned PW = W1 + W2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W1-1:0] in_a, lyr_a;
  logic [W2-1:0] in_b;
  logic          lyr_b_low, lyr_b_high, lyr_cin, out_ovf;
  logic [W1+1:0] lyr_sum;
  logic [PW-1:0] out_prod;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          mode   = 0;   // 0 exact layer, 1 constant stub, 2 per-cycle random values
  logic [9:0]  stub_val = '0;
  logic [9:0]  vals  [L];
  logic [1:0]  pairs [L];

  app_layer_seq_accum #(.WIDTH1(W1), .WIDTH2(W2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .lyr_a(lyr_a), .lyr_b_low(lyr_b_low),
    .lyr_b_high(lyr_b_high), .lyr_cin(lyr_cin), .lyr_sum(lyr_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod),
    .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  // Behavioural layer: exact partial product A * {B_high, B_low}, or a driven value.
  always_comb begin
    if (mode == 0) lyr_sum = 10'(lyr_a) * 10'({lyr_b_high, lyr_b_low});
    else           lyr_sum = stub_val;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'(1));
    in_valid = 1'b1; in_a = a; in_b = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (lat < int'(L)) begin
        pairs[lat[1:0]] = {lyr_b_high, lyr_b_low};
        if (mode == 2) stub_val = vals[lat[1:0]];
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_op;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_after_done", 64'(out_valid), 64'(0));
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] prod, output logic ovf);
    int lat;
    start_op(a, b);
    wait_done(lat);
    check("latency", 64'(lat), 64'(L));
    check("lyr_a_held", 64'(lyr_a), 64'(a));
    prod = out_prod;
    ovf  = out_ovf;
    finish_op();
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    logic        o;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [15:0] prod, p0;
    logic        ovf, exp_o;
    logic [63:0] total, exp_p;
    logic [7:0]  ra, rb;
    logic [7:0]  ba[3], bb[3];
    int          sent, got, c, lat;
    int          tdone[3];

    tbl[0] = '{8'd200, 8'd150, 16'd30000, 1'b0};
    tbl[1] = '{8'd0,   8'hC6,  16'd0,     1'b0};
    tbl[2] = '{8'd255, 8'd255, 16'd65025, 1'b0};
    tbl[3] = '{8'd15,  8'd15,  16'd225,   1'b0};
    tbl[4] = '{8'd1,   8'h80,  16'd128,   1'b0};
    tbl[5] = '{8'd255, 8'd0,   16'd0,     1'b0};
    tbl[6] = '{8'd3,   8'd255, 16'd765,   1'b0};
    tbl[7] = '{8'd128, 8'd2,   16'd256,   1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_prod",  64'(out_prod),  64'(0));
    check("rst_out_ovf",   64'(out_ovf),   64'(0));
    check("rst_lyr_a",     64'(lyr_a),     64'(0));
    check("rst_lyr_bits",  64'({lyr_b_high, lyr_b_low, lyr_cin}), 64'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      mode = 0;
      run_op(tbl[i].a, tbl[i].b, prod, ovf);
      check($sformatf("tbl%0d_prod", i), 64'(prod), 64'(tbl[i].p));
      check($sformatf("tbl%0d_ovf", i),  64'(ovf),  64'(tbl[i].o));
    end

    // Bit-pair order for B = 0xC6: low pair first.
    run_op(8'd0, 8'hC6, prod, ovf);
    check("pair0", 64'(pairs[0]), 64'(2'b10));
    check("pair1", 64'(pairs[1]), 64'(2'b01));
    check("pair2", 64'(pairs[2]), 64'(2'b00));
    check("pair3", 64'(pairs[3]), 64'(2'b11));
    check("pairs_prod", 64'(prod), 64'(0));

    // Constant 0x3FF layer output: 1023 * (1 + 4 + 16 + 64) = 86955.
    mode = 1; stub_val = 10'h3FF;
    run_op(8'h12, 8'h34, prod, ovf);
`ifdef APP_LAYER_ACC_SAT_EN
    check("ovf_prod", 64'(prod), 64'(16'hFFFF));
    check("ovf_flag", 64'(ovf),  64'(1));
`else
    check("ovf_prod", 64'(prod), 64'(21419));
    check("ovf_flag", 64'(ovf),  64'(0));
`endif

    // Random layer sums: result is sum(v_k * 4^k), saturated or wrapped.
    mode = 2;
    for (int t = 0; t < 16; t++) begin
      total = '0;
      for (int j = 0; j < int'(L); j++) begin
        vals[j] = (t[0]) ? 10'($urandom_range(700, 1023)) : 10'($urandom_range(0, 1023));
        total   = total + (64'(vals[j]) << (2 * j));
      end
`ifdef APP_LAYER_ACC_SAT_EN
      exp_o = (total > 64'hFFFF);
      exp_p = exp_o ? 64'hFFFF : total;
`else
      exp_o = 1'b0;
      exp_p = total & 64'hFFFF;
`endif
      ra = 8'($urandom); rb = 8'($urandom);
      run_op(ra, rb, prod, ovf);
      check($sformatf("rndlyr%0d_prod", t), 64'(prod), exp_p);
      check($sformatf("rndlyr%0d_ovf", t),  64'(ovf),  64'(exp_o));
    end

    // Random operands with the exact layer.
    mode = 0;
    for (int t = 0; t < 16; t++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      run_op(ra, rb, prod, ovf);
      check($sformatf("rnd%0d_prod", t), 64'(prod), 64'(16'(ra) * 16'(rb)));
      check($sformatf("rnd%0d_ovf", t),  64'(ovf),  64'(0));
    end

    // Backpressure: result held in DONE, second operand waits for IDLE.
    start_op(8'd12, 8'd34);
    wait_done(lat);
    check("bp_latency", 64'(lat), 64'(L));
    p0 = out_prod;
    check("bp_prod", 64'(p0), 64'(408));
    in_valid = 1'b1; in_a = 8'd56; in_b = 8'd78;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_prod",  64'(out_prod),  64'(408));
      check("bp_hold_valid", 64'(out_valid), 64'(1));
      check("bp_hold_ready", 64'(in_ready),  64'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle_valid", 64'(out_valid), 64'(0));
    check("bp_idle_ready", 64'(in_ready),  64'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_taken", 64'(in_ready), 64'(0));
    wait_done(lat);
    check("bp2_latency", 64'(lat), 64'(L));
    check("bp2_prod", 64'(out_prod), 64'(4368));
    finish_op();

    // Reset during RUN cycle 2, then a fresh operation.
    start_op(8'd100, 8'd100);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_in_ready",  64'(in_ready),  64'(1));
    check("mrst_out_valid", 64'(out_valid), 64'(0));
    check("mrst_out_prod",  64'(out_prod),  64'(0));
    check("mrst_out_ovf",   64'(out_ovf),   64'(0));
    check("mrst_lyr_a",     64'(lyr_a),     64'(0));
    check("mrst_lyr_bits",  64'({lyr_b_high, lyr_b_low, lyr_cin}), 64'(0));
    @(negedge clk);
    check("mrst_no_valid", 64'(out_valid), 64'(0));
    rst_n = 1'b1;
    run_op(8'd15, 8'd15, prod, ovf);
    check("mrst_prod", 64'(prod), 64'(225));

    // Back-to-back with in_valid and out_ready held high.
    for (int i = 0; i < 3; i++) begin
      ba[i] = 8'($urandom); bb[i] = 8'($urandom);
    end
    sent = 0; got = 0; c = 0;
    out_ready = 1'b1;
    while (got < 3 && c < 100) begin
      @(negedge clk);
      c++;
      if (out_valid) begin
        check($sformatf("b2b%0d_prod", got), 64'(out_prod), 64'(16'(ba[got]) * 16'(bb[got])));
        tdone[got] = c;
        got++;
      end
      if (in_ready) begin
        if (sent < 3) begin
          in_valid = 1'b1; in_a = ba[sent]; in_b = bb[sent];
          sent++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_count", 64'(got), 64'(3));
    if (got == 3) begin
      check("b2b_gap01", 64'(tdone[1] - tdone[0]), 64'(L + 2));
      check("b2b_gap12", 64'(tdone[2] - tdone[1]), 64'(L + 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
